// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-width encodings,
// sequencer states and the access legality/alignment rule.
package lsu_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } lsu_state_e;

  // Unsigned widths exist only for loads; halves and words need natural alignment.
  function automatic logic ls_access_ok(input logic [2:0] mode,
                                        input logic       rw,
                                        input logic [1:0] addr_lo);
    logic ok_v;
    case (mode)
      LS_B:    ok_v = 1'b1;
      LS_BU:   ok_v = ~rw;
      LS_H:    ok_v = ~addr_lo[0];
      LS_HU:   ok_v = ~rw & ~addr_lo[0];
      LS_W:    ok_v = (addr_lo == 2'b00);
      default: ok_v = 1'b0;
    endcase
    return ok_v;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and replicated store data on the
// way out, byte/halfword selection and extension on the way back.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_addr_lo,
  input  logic [2:0]  st_mode,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_aligned,
  input  logic [1:0]  ld_addr_lo,
  input  logic [2:0]  ld_mode,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_ext
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  assign ld_byte_s = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
  assign ld_half_s = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

  // Store path: enables follow the access width, data is replicated into every lane.
  always_comb begin
    st_be            = 4'b0000;
    st_wdata_aligned = 32'h0000_0000;
    case (st_mode)
      LS_B, LS_BU: begin
        st_be            = 4'b0001 << st_addr_lo;
        st_wdata_aligned = {4{st_wdata[7:0]}};
      end
      LS_H, LS_HU: begin
        st_be            = 4'b0011 << {st_addr_lo[1], 1'b0};
        st_wdata_aligned = {2{st_wdata[15:0]}};
      end
      LS_W: begin
        st_be            = 4'b1111;
        st_wdata_aligned = st_wdata;
      end
      default: begin
        st_be            = 4'b0000;
        st_wdata_aligned = 32'h0000_0000;
      end
    endcase
  end

  // Load path: pick the addressed lane and extend to 32 bits.
  always_comb begin
    ld_ext = 32'h0000_0000;
    case (ld_mode)
      LS_B:    ld_ext = {{24{ld_byte_s[7]}}, ld_byte_s};
      LS_BU:   ld_ext = {24'h00_0000, ld_byte_s};
      LS_H:    ld_ext = {{16{ld_half_s[15]}}, ld_half_s};
      LS_HU:   ld_ext = {16'h0000, ld_half_s};
      LS_W:    ld_ext = ld_rdata;
      default: ld_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: launches one req/ack bus transaction per memory
// instruction, stalls the pipeline while it is outstanding, reports faults.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_en,
  input  logic              mem_rw,
  input  logic [2:0]        ls_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       ld_data,
  output logic              ld_valid,
  output logic              fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [31:0]       bus_rdata
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  lsu_state_e  state_r;
  lsu_state_e  state_s;
  logic [15:0] cnt_r;
  logic [1:0]  addr_lo_r;
  logic [2:0]  mode_r;
  logic        access_ok_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_al_s;
  logic [31:0] ld_ext_s;

  assign access_ok_s = ls_access_ok(ls_mode, mem_rw, addr[1:0]);
  assign stall       = ((state_r == ST_IDLE) & mem_en & access_ok_s) | (state_r == ST_REQ);

  lsu_lane_align u_lane_align (
    .st_addr_lo       (addr[1:0]),
    .st_mode          (ls_mode),
    .st_wdata         (wdata),
    .st_be            (be_s),
    .st_wdata_aligned (wdata_al_s),
    .ld_addr_lo       (addr_lo_r),
    .ld_mode          (mode_r),
    .ld_rdata         (bus_rdata),
    .ld_ext           (ld_ext_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; ack/err outrank the timeout in the same cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_en) begin
          state_s = access_ok_s ? ST_REQ : ST_ERR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_err) begin
          state_s = ST_ERR;
        end else if (bus_ack) begin
          state_s = ST_DONE;
        end else if (cnt_r == TO_LAST) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      ST_ERR:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Bus launch/hold, timeout counter, load capture and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0000_0000;
      ld_data   <= 32'h0000_0000;
      ld_valid  <= 1'b0;
      fault     <= 1'b0;
      cnt_r     <= 16'd0;
      addr_lo_r <= 2'b00;
      mode_r    <= 3'b000;
    end else begin
      ld_valid <= (state_s == ST_DONE) & ~bus_we;
      fault    <= (state_s == ST_ERR);
      case (state_r)
        ST_IDLE: begin
          if (mem_en && access_ok_s) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_rw;
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_be    <= be_s;
            bus_wdata <= wdata_al_s;
            addr_lo_r <= addr[1:0];
            mode_r    <= ls_mode;
            cnt_r     <= 16'd0;
          end
        end
        ST_REQ: begin
          if (bus_ack || bus_err) begin
            bus_req <= 1'b0;
            if (bus_ack && !bus_err && !bus_we) begin
              ld_data <= ld_ext_s;
            end
          end else if (cnt_r == TO_LAST) begin
            bus_req <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed and randomized checks of lsu_ctrl against a byte-arithmetic model.
module tb_lsu_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_en, mem_rw;
  logic [2:0]  ls_mode;
  logic [31:0] addr, wdata;
  logic        stall, ld_valid, fault;
  logic [31:0] ld_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [31:0] ld_model  = 32'h0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .mem_rw(mem_rw), .ls_mode(ls_mode),
    .addr(addr), .wdata(wdata), .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid),
    .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes and derived quantities.
  function automatic int unsigned sz(input logic [2:0] m);
    return 32'd1 << m[1:0];
  endfunction

  function automatic bit model_ok(input logic rw, input logic [2:0] m, input logic [31:0] a);
    bit legal;
    legal = (m == 3'd0) || (m == 3'd1) || (m == 3'd2) || (!rw && (m == 3'd4 || m == 3'd5));
    return legal && ((a % sz(m)) == 0);
  endfunction

  function automatic int unsigned model_off(input logic [2:0] m, input logic [31:0] a);
    return ((a % 4) / sz(m)) * sz(m);
  endfunction

  function automatic logic [31:0] model_be(input logic [2:0] m, input logic [31:0] a);
    return ((32'd1 << sz(m)) - 32'd1) << model_off(m, a);
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] m, input logic [31:0] wd);
    if (sz(m) == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz(m) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_ld(input logic [2:0] m, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v, mask;
    int unsigned bits;
    bits = 8 * sz(m);
    v = rd >> (8 * model_off(m, a));
    if (bits < 32) begin
      mask = (32'd1 << bits) - 32'd1;
      v = v & mask;
      if (!m[2] && v >= (32'd1 << (bits - 1))) v = v | ~mask;
    end
    return v;
  endfunction

  // One memory instruction starting in an IDLE cycle; ack_k is the REQ cycle
  // (0-based) carrying the response, ack_k >= TO means the bus never answers.
  task automatic do_access(input logic rw, input logic [2:0] m, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int ack_k,
                           input logic err, input logic ack_w_err, input logic stray);
    bit ok, responded;
    ok = model_ok(rw, m, a);
    responded = 1'b0;
    @(negedge clk);
    bus_ack = 1'b0; bus_err = 1'b0;
    chk("idle_ld_valid", {31'd0, ld_valid}, 32'd0);
    chk("idle_fault", {31'd0, fault}, 32'd0);
    chk("idle_bus_req", {31'd0, bus_req}, 32'd0);
    mem_en = 1'b1; mem_rw = rw; ls_mode = m; addr = a; wdata = wd;
    #1;
    chk("idle_stall", {31'd0, stall}, {31'd0, ok});
    if (!ok) begin
      @(negedge clk);
      mem_en = 1'b0;
      chk("bad_fault", {31'd0, fault}, 32'd1);
      chk("bad_bus_req", {31'd0, bus_req}, 32'd0);
      chk("bad_stall", {31'd0, stall}, 32'd0);
      chk("bad_ld_valid", {31'd0, ld_valid}, 32'd0);
      chk("bad_ld_data", ld_data, ld_model);
      bus_ack = stray;
      return;
    end
    for (int k = 0; k < int'(TO); k++) begin
      @(negedge clk);
      mem_en = 1'b0;
      chk("req_bus_req", {31'd0, bus_req}, 32'd1);
      chk("req_stall", {31'd0, stall}, 32'd1);
      chk("req_bus_addr", bus_addr, a & 32'hFFFF_FFFC);
      chk("req_bus_we", {31'd0, bus_we}, {31'd0, rw});
      chk("req_bus_be", {28'd0, bus_be}, model_be(m, a));
      if (rw) chk("req_bus_wdata", bus_wdata, model_wd(m, wd));
      if (k == ack_k) begin
        bus_err   = err;
        bus_ack   = err ? ack_w_err : 1'b1;
        bus_rdata = rd;
        responded = 1'b1;
        break;
      end
    end
    @(negedge clk);
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
    chk("end_bus_req", {31'd0, bus_req}, 32'd0);
    chk("end_stall", {31'd0, stall}, 32'd0);
    if (responded && !err) begin
      if (!rw) ld_model = model_ld(m, a, rd);
      chk("done_ld_valid", {31'd0, ld_valid}, {31'd0, ~rw});
      chk("done_fault", {31'd0, fault}, 32'd0);
    end else begin
      chk("err_fault", {31'd0, fault}, 32'd1);
      chk("err_ld_valid", {31'd0, ld_valid}, 32'd0);
    end
    chk("end_ld_data", ld_data, ld_model);
    bus_ack = stray;
  endtask

  task automatic chk_reset_vals();
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_ld_valid", {31'd0, ld_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; mem_en = 1'b0; mem_rw = 1'b0; ls_mode = 3'd0; addr = 32'd0;
    wdata = 32'd0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals();

    // LW, ack in the third REQ cycle
    do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, 1'b0, 1'b0);
    chk("lw_data", ld_data, 32'hDEAD_BEEF);
    do_access(1'b0, 3'b000, 32'h203, 32'h0, 32'h8011_2233, 0, 1'b0, 1'b0, 1'b0);
    chk("lb_data", ld_data, 32'hFFFF_FF80);
    do_access(1'b0, 3'b100, 32'h203, 32'h0, 32'h8011_2233, 1, 1'b0, 1'b0, 1'b0);
    chk("lbu_data", ld_data, 32'h0000_0080);
    do_access(1'b0, 3'b101, 32'h202, 32'h0, 32'h8011_2233, 0, 1'b0, 1'b0, 1'b0);
    chk("lhu_data", ld_data, 32'h0000_8011);
    // SH with immediate ack, then misaligned LW and illegal SW-with-BU
    do_access(1'b1, 3'b001, 32'h12, 32'hAAAA_1234, 32'h0, 0, 1'b0, 1'b0, 1'b1);
    chk("sh_wdata", bus_wdata, 32'h1234_1234);
    do_access(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    do_access(1'b1, 3'b100, 32'h200, 32'h5, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    // Timeout, and ack on the last counted cycle
    do_access(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, int'(TO), 1'b0, 1'b0, 1'b0);
    do_access(1'b0, 3'b010, 32'h404, 32'h0, 32'h1357_9BDF, int'(TO) - 1, 1'b0, 1'b0, 1'b0);
    chk("late_ack_data", ld_data, 32'h1357_9BDF);
    do_access(1'b0, 3'b001, 32'h406, 32'h0, 32'hFFFF_FFFF, 1, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a request
    @(negedge clk);
    bus_ack = 1'b0;
    mem_en = 1'b1; mem_rw = 1'b0; ls_mode = 3'b010; addr = 32'h300;
    @(negedge clk);
    mem_en = 1'b0;
    chk("mid_bus_req", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ld_model = 32'h0;
    chk_reset_vals();
    do_access(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 1'b0, 1'b0);

    // Randomized back-to-back traffic
    for (int i = 0; i < 80; i++) begin
      do_access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0),
                1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    bus_ack = 1'b0;
    @(negedge clk);
    chk("final_bus_req", {31'd0, bus_req}, 32'd0);
    chk("final_ld_data", ld_data, ld_model);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
